// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state type, parity mode encodings and the
// baud divisor helper used by both the RX and TX sides.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } uart_rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Core clocks per bit time.
    function automatic int unsigned uart_delay_frames(input int unsigned freq_mhz,
                                                      input int unsigned baud);
        return (freq_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops reset to 1 (idle-high lines)
//   d     - asynchronous input
//   q     - synchronized output, two cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d};
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS payload (5..9), none/odd/even parity, 1 or 2
// stop bits. Single-entry holding register with valid/ready handshake.
// Ports:
//   clk, rst_n  - core clock, asynchronous active-low reset
//   uart_rx     - asynchronous serial line, idle high
//   rdata       - received payload (LSB first on the wire)
//   rvalid      - rdata/frame_err/parity_err valid; held until rvalid && rready
//   rready      - consumer accepts the word
//   frame_err   - a stop bit was sampled low for this word
//   parity_err  - parity mismatch for this word (0 when parity is disabled)
//   overrun     - sticky: a completed frame was dropped because the holding reg was full
//   break_det   - one-cycle pulse when a break is detected
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned FREQUENCY_MHz = 27,
    parameter int unsigned BAUDRATE      = 115200,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det
);

`ifdef FAST_UART
    localparam int unsigned DELAY_FRAMES = 2;
`else
    localparam int unsigned DELAY_FRAMES = uart_delay_frames(FREQUENCY_MHz, BAUDRATE);
`endif
    localparam int unsigned HALF = DELAY_FRAMES / 2;
    localparam int unsigned CW   = $clog2(DELAY_FRAMES) + 1;
    localparam int unsigned IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_BIT   = CW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    logic rxs;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rxs)
    );

    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pbit_q, pbit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 stop0_q, stop0_d;
    logic                 ferr_q, ferr_d;

    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;

    logic bit_tick;
    logic complete;
    logic ferr_now;
    logic perr_now;
    logic first_stop;
    logic is_break;
    logic accept;
    logic load;
    logic drop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        pbit_d     = pbit_q;
        stop_idx_d = stop_idx_q;
        stop0_d    = stop0_q;
        ferr_d     = ferr_q;
        complete   = 1'b0;
        bit_tick   = (cnt_q == CNT_BIT);

        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CNT_HALF) begin
                    // Line back high at mid start bit: noise, drop silently.
                    if (rxs) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StData;
                        cnt_d      = '0;
                        idx_d      = '0;
                        stop_idx_d = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    pbit_d  = rxs;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rxs;
                    if (stop_idx_q == 1'b0) begin
                        stop0_d = rxs;
                    end
                    if (stop_idx_q == STOP_LAST) begin
                        complete = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreakWait: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame completion uses the stop sample taken this very cycle.
        ferr_now   = ferr_q | ~rxs;
        first_stop = (STOP_BITS == 1) ? rxs : stop0_q;
        perr_now   = (PARITY == PAR_NONE) ? 1'b0
                                          : ((^shreg_q ^ pbit_q) != (PARITY == PAR_ODD));
        is_break   = (shreg_q == '0) && ((PARITY == PAR_NONE) || !pbit_q) && !first_stop;

        if (complete) begin
            // A low stop bit means the line may still be low; wait for idle first.
            state_d = (is_break || ferr_now) ? StBreakWait : StIdle;
        end

        accept = rvalid_q && rready;
        load   = complete && !is_break && (!rvalid_q || rready);
        drop   = complete && !is_break && rvalid_q && !rready;

        rvalid_d     = load | (rvalid_q & ~accept);
        rdata_d      = load ? shreg_q : rdata_q;
        frame_err_d  = load ? ferr_now : frame_err_q;
        parity_err_d = load ? perr_now : parity_err_q;
        overrun_d    = drop ? 1'b1 : (accept ? 1'b0 : overrun_q);
        break_d      = complete && is_break;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            pbit_q       <= 1'b0;
            stop_idx_q   <= 1'b0;
            stop0_q      <= 1'b0;
            ferr_q       <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            pbit_q       <= pbit_d;
            stop_idx_q   <= stop_idx_d;
            stop0_q      <= stop0_d;
            ferr_q       <= ferr_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised next-generation UART receiver.
- Configurable data width, parity mode and stop-bit count; 2-flop input synchronizer; false-start rejection.
- Single-entry output holding register with valid/ready handshake; framing, parity, overrun and break reporting.
- Feeds the loader / MMIO UART path in place of the fixed 8N1 receiver.

Parameters:
- FREQUENCY_MHz, 27, core clock in MHz.
- BAUDRATE, 115200, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  asynchronous serial line; idle high.
- rdata  out  DATA_BITS  received payload, LSB first on the wire.
- rvalid  out  1  rdata and error flags are valid.
- rready  in  1  consumer accepts the word.
- frame_err  out  1  stop bit(s) sampled low for this word.
- parity_err  out  1  parity mismatch for this word; always 0 when PARITY = 0.
- overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- break_det  out  1  one-cycle pulse on break detection.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Port names are clk and rst_n.
- Under reset: state IDLE; counters 0; synchronizer flops 1; rdata 0; rvalid, frame_err, parity_err, overrun and break_det all 0.
- Timing: DELAY_FRAMES = FREQUENCY_MHz*1000000/BAUDRATE, or 2 when FAST_UART is defined. HALF = DELAY_FRAMES/2. The counter is sized by $clog2(DELAY_FRAMES)+1.
- Line input: rxs is uart_rx after a 2-flop synchronizer, giving 2 cycles of latency. All decisions use rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: on rxs == 0, go to START with cnt = 0.
- START: count to HALF-1.
  - If rxs == 1 at that point, it is a false start: return to IDLE and do not flag an error.
  - Otherwise go to DATA with cnt = 0 and bit index 0.
- DATA: every DELAY_FRAMES cycles, shift rxs into shreg[idx].
  - After bit DATA_BITS-1, go to PARITY if PARITY != 0, else to STOP.
- PARITY: sample one bit after DELAY_FRAMES cycles.
  - perr = (^shreg ^ pbit) != (PARITY == 1).
  - Odd mode: total count of ones incl. parity must be odd. Even mode: must be even.
- STOP: sample STOP_BITS bits at DELAY_FRAMES spacing. ferr = any stop sample == 0.
- Frame completion, on the cycle of the last stop sample:
  - Break condition: shreg == 0, parity bit 0 (if present), and first stop sample 0.
  - If break: pulse break_det for 1 cycle, do not load the holding register, go to BREAK_WAIT.
  - Otherwise, if holding register free (rvalid == 0, or rready == 1 this cycle): next cycle rdata = shreg, frame_err = ferr, parity_err = perr, rvalid = 1.
  - Otherwise set overrun = 1 and discard the word.
  - If ferr and not break, go to BREAK_WAIT; else go to IDLE.
  - Going directly to IDLE allows back-to-back frames with no idle gap.
- BREAK_WAIT: stay until rxs == 1, then go to IDLE. This prevents a stuck-low line from being parsed as endless frames.
- Handshake:
  - rvalid stays high with rdata and the error flags stable until the cycle where rvalid && rready.
  - rvalid falls next cycle unless a new word loads in that same cycle, in which case it stays 1 with the new data.
- Overrun: cleared only by reset, or by a cycle with rvalid && rready && no new drop.
- Reset mid-frame: returns to IDLE immediately. A partially received frame is lost with no flag raised.
- Illegal parameters (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS outside 1..2) are rejected by an elaboration-time $error.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t.
  - Parity constants PAR_NONE, PAR_ODD, PAR_EVEN.
  - Function uart_delay_frames(freq_mhz, baud) computing the baud divisor, shared with the TX side.
- One sub-module: sync_2ff (2-flop synchronizer with reset value 1), reusable for other async inputs.

Test Plan:
All cases use FREQUENCY_MHz=1, BAUDRATE=100000 (DELAY_FRAMES=10), unless stated otherwise.
- 8N1, send 0xA5, rready held 1 -> rvalid pulses for 1 cycle with rdata=0xA5; frame_err=0; parity_err=0.
- DATA_BITS=7, PARITY=2, send 0x35 with correct even parity 0, then the same word with parity 1 -> first word parity_err=0, second parity_err=1, rdata=0x35 both.
- Glitch: uart_rx low for 3 cycles, then high -> no rvalid, FSM back in IDLE, no error flags.
- STOP_BITS=2, second stop bit low, data 0x41 -> rvalid with rdata=0x41 and frame_err=1; FSM waits in BREAK_WAIT until the line goes high.
- rready held 0, two frames 0x11 then 0x22 -> rdata stays 0x11 and overrun=1; after one accept cycle rvalid=0 and overrun=0.
- Line held low for 30 bit times -> exactly one break_det pulse, no rvalid; a following frame 0x5A received normally once the line returns high.
